// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry constants and address/clamp helpers for the 3x3 conv tile engine
package conv_pkg;
    localparam int IFM_W         = 58;
    localparam int OFM_W         = 56;
    localparam int IFM_DEPTH     = 13456;
    localparam int W_DEPTH       = 72;
    localparam int OUT_DEPTH     = 32768;
    localparam int NUM_PE        = 16;
    localparam int NUM_PASS      = 2;
    localparam int STEPS_PER_PIX = 36;

    // step s walks kernel row (s/12), kernel column ((s%12)/4) and channel word (s%4)
    function automatic logic [13:0] ifm_addr(input logic [5:0] r, input logic [5:0] c, input logic [5:0] s);
        logic [1:0]  kr;
        logic [1:0]  kc;
        logic [13:0] row;
        logic [13:0] col;
        kr  = (s >= 6'd24) ? 2'd2 : (s >= 6'd12) ? 2'd1 : 2'd0;
        kc  = 2'((s - 6'(kr) * 6'd12) >> 2);
        row = 14'(r) + 14'(kr);
        col = 14'(c) + 14'(kc);
        return (row * 14'(IFM_W) + col) * 14'd4 + 14'(s[1:0]);
    endfunction

    function automatic logic [6:0] w_addr(input logic pass, input logic [5:0] s);
        return 7'(pass) * 7'(STEPS_PER_PIX) + 7'(s);
    endfunction

    function automatic logic [7:0] relu_sat(input logic signed [31:0] v);
        return (v < 0) ? 8'd0 : (v > 32'sd255) ? 8'hFF : v[7:0];
    endfunction
endpackage

// File: rtl/conv_pe.sv
// conv_pe: 4-lane unsigned-IFM x signed-weight MAC with accumulator, ReLU/saturate and valid pulse
module conv_pe
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_ifm,
    input  logic [31:0] i_w,
    input  logic        i_first,
    input  logic        i_last,
    output logic [7:0]  o_result,
    output logic        o_valid
);
    logic signed [16:0] w_lane [4];
    logic signed [31:0] w_prod;
    logic signed [31:0] w_sum;
    logic signed [31:0] r_acc;
    logic [7:0]         r_result;
    logic               r_valid;

    always_comb begin
        w_lane = '{default: '0};
        w_prod = '0;
        for (int j = 0; j < 4; j++) begin
            w_lane[j] = $signed({9'd0, i_ifm[31-8*j -: 8]}) * $signed({{9{i_w[31-8*j]}}, i_w[31-8*j -: 8]});
            w_prod    = w_prod + {{15{w_lane[j][16]}}, w_lane[j]};
        end
    end

    assign w_sum = i_first ? w_prod : r_acc + w_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_acc   <= w_sum;
            r_valid <= i_last;
            if (i_last)
                r_result <= relu_sat(w_sum);
        end
    end

    assign o_result = r_result;
    assign o_valid  = r_valid;
endmodule

// File: rtl/sub_top_2_conv.sv
// sub_top_2_conv: 3x3 conv tile engine with IFM/weight BRAMs, address generator, 16 MAC PEs and output BRAM
module sub_top_2_conv
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_rd_en_IFM,
    input  logic        wr_rd_en_Weight,
    input  logic [31:0] addr,
    input  logic [31:0] data_in_IFM,
    input  logic [31:0] data_in_Weight_0,
    input  logic [31:0] data_in_Weight_1,
    input  logic [31:0] data_in_Weight_2,
    input  logic [31:0] data_in_Weight_3,
    input  logic [31:0] data_in_Weight_4,
    input  logic [31:0] data_in_Weight_5,
    input  logic [31:0] data_in_Weight_6,
    input  logic [31:0] data_in_Weight_7,
    input  logic [31:0] data_in_Weight_8,
    input  logic [31:0] data_in_Weight_9,
    input  logic [31:0] data_in_Weight_10,
    input  logic [31:0] data_in_Weight_11,
    input  logic [31:0] data_in_Weight_12,
    input  logic [31:0] data_in_Weight_13,
    input  logic [31:0] data_in_Weight_14,
    input  logic [31:0] data_in_Weight_15,
    input  logic        cal_start,
    input  logic [15:0] PE_reset,
    input  logic [15:0] PE_finish,
    output logic [15:0] valid,
    input  logic        wr_en_next,
    input  logic [31:0] addr_ram_next_wr,
    input  logic [31:0] addr_ram_next_rd,
    input  logic [1:0]  control_mux,
    output logic [31:0] out_BRAM_CONV
);
    logic [5:0]  r_s;
    logic [5:0]  r_c;
    logic [5:0]  r_r;
    logic        r_pass;
    logic        r_done;
    logic [13:0] r_ifm_addr;
    logic [6:0]  r_w_addr;
    logic        w_last_s;
    logic        w_last_c;
    logic        w_last_r;
    logic        w_last_all;

    logic [31:0] r_ifm_mem [IFM_DEPTH];
    logic [31:0] r_ifm_q;
    logic [31:0] r_ifm_d;
    logic [31:0] r_w_mem [NUM_PE][W_DEPTH];
    logic [31:0] r_w_q [NUM_PE];
    logic [31:0] r_w_d [NUM_PE];
    logic [31:0] w_w_in [NUM_PE];

    logic [7:0]  w_res [NUM_PE];
    logic [31:0] w_pack;
    logic [31:0] r_out_mem [OUT_DEPTH];
    logic [31:0] r_out;
    logic        w_unused;

    assign w_w_in[0]  = data_in_Weight_0;
    assign w_w_in[1]  = data_in_Weight_1;
    assign w_w_in[2]  = data_in_Weight_2;
    assign w_w_in[3]  = data_in_Weight_3;
    assign w_w_in[4]  = data_in_Weight_4;
    assign w_w_in[5]  = data_in_Weight_5;
    assign w_w_in[6]  = data_in_Weight_6;
    assign w_w_in[7]  = data_in_Weight_7;
    assign w_w_in[8]  = data_in_Weight_8;
    assign w_w_in[9]  = data_in_Weight_9;
    assign w_w_in[10] = data_in_Weight_10;
    assign w_w_in[11] = data_in_Weight_11;
    assign w_w_in[12] = data_in_Weight_12;
    assign w_w_in[13] = data_in_Weight_13;
    assign w_w_in[14] = data_in_Weight_14;
    assign w_w_in[15] = data_in_Weight_15;

    assign w_last_s   = r_s == 6'(STEPS_PER_PIX - 1);
    assign w_last_c   = r_c == 6'(OFM_W - 1);
    assign w_last_r   = r_r == 6'(OFM_W - 1);
    assign w_last_all = w_last_s && w_last_c && w_last_r && (r_pass == 1'(NUM_PASS - 1));

    // addresses are registered here, so data for the step issued on edge n is consumed by the PEs on edge n+3
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_pass     <= 1'b0;
            r_done     <= 1'b0;
            r_ifm_addr <= '0;
            r_w_addr   <= '0;
        end else if (cal_start && !r_done) begin
            r_ifm_addr <= ifm_addr(r_r, r_c, r_s);
            r_w_addr   <= w_addr(r_pass, r_s);
            if (w_last_all)
                r_done <= 1'b1;
            else begin
                r_s <= w_last_s ? '0 : r_s + 6'd1;
                if (w_last_s)
                    r_c <= w_last_c ? '0 : r_c + 6'd1;
                if (w_last_s && w_last_c)
                    r_r <= w_last_r ? '0 : r_r + 6'd1;
                if (w_last_s && w_last_c && w_last_r)
                    r_pass <= r_pass + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_rd_en_IFM)
            r_ifm_mem[addr[13:0]] <= data_in_IFM;
        r_ifm_q <= r_ifm_mem[r_ifm_addr];
        r_ifm_d <= r_ifm_q;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PE; k++) begin
            if (wr_rd_en_Weight)
                r_w_mem[k][addr[6:0]] <= w_w_in[k];
            r_w_q[k] <= r_w_mem[k][r_w_addr];
            r_w_d[k] <= r_w_q[k];
        end
    end

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        conv_pe u_pe (
            .clk      (clk),
            .reset    (reset),
            .i_ifm    (r_ifm_d),
            .i_w      (r_w_d[k]),
            .i_first  (PE_reset[k]),
            .i_last   (PE_finish[k]),
            .o_result (w_res[k]),
            .o_valid  (valid[k])
        );
    end

    assign w_pack = {w_res[{control_mux, 2'd0}], w_res[{control_mux, 2'd1}],
                     w_res[{control_mux, 2'd2}], w_res[{control_mux, 2'd3}]};

    always_ff @(posedge clk) begin
        if (wr_en_next)
            r_out_mem[addr_ram_next_wr[14:0]] <= w_pack;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_out <= '0;
        else
            r_out <= r_out_mem[addr_ram_next_rd[14:0]];
    end

    assign out_BRAM_CONV = r_out;
    assign w_unused      = ^{addr[31:14], addr_ram_next_wr[31:15], addr_ram_next_rd[31:15]};
endmodule

// File: tb/tb_sub_top_2_conv.sv
// tb_sub_top_2_conv: table-driven bench with a result scoreboard for the 3x3 conv tile engine
module tb_sub_top_2_conv;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_rd_en_IFM;
    logic        wr_rd_en_Weight;
    logic [31:0] addr;
    logic [31:0] data_in_IFM;
    logic [31:0] w_in [16];
    logic        cal_start;
    logic [15:0] PE_reset;
    logic [15:0] PE_finish;
    logic [15:0] valid;
    logic        wr_en_next;
    logic [31:0] addr_ram_next_wr;
    logic [31:0] addr_ram_next_rd;
    logic [1:0]  control_mux;
    logic [31:0] out_BRAM_CONV;

    typedef struct {
        logic [7:0]   ifm_b;
        logic [7:0]   w_b;
        bit           w_idx;
        bit           one_hot;
        logic [127:0] exp0;
        logic [127:0] exp1;
    } vec_t;

    vec_t         tbl [5];
    logic [127:0] exp_pix [2];
    logic [127:0] q [$];
    int           checks = 0;
    int           errors = 0;

    sub_top_2_conv dut (
        .clk(clk), .reset(reset),
        .wr_rd_en_IFM(wr_rd_en_IFM), .wr_rd_en_Weight(wr_rd_en_Weight),
        .addr(addr), .data_in_IFM(data_in_IFM),
        .data_in_Weight_0(w_in[0]),   .data_in_Weight_1(w_in[1]),
        .data_in_Weight_2(w_in[2]),   .data_in_Weight_3(w_in[3]),
        .data_in_Weight_4(w_in[4]),   .data_in_Weight_5(w_in[5]),
        .data_in_Weight_6(w_in[6]),   .data_in_Weight_7(w_in[7]),
        .data_in_Weight_8(w_in[8]),   .data_in_Weight_9(w_in[9]),
        .data_in_Weight_10(w_in[10]), .data_in_Weight_11(w_in[11]),
        .data_in_Weight_12(w_in[12]), .data_in_Weight_13(w_in[13]),
        .data_in_Weight_14(w_in[14]), .data_in_Weight_15(w_in[15]),
        .cal_start(cal_start), .PE_reset(PE_reset), .PE_finish(PE_finish),
        .valid(valid), .wr_en_next(wr_en_next),
        .addr_ram_next_wr(addr_ram_next_wr), .addr_ram_next_rd(addr_ram_next_rd),
        .control_mux(control_mux), .out_BRAM_CONV(out_BRAM_CONV)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] pack(input logic [127:0] e, input int m);
        return {e[8*(4*m) +: 8], e[8*(4*m+1) +: 8], e[8*(4*m+2) +: 8], e[8*(4*m+3) +: 8]};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        cal_start = 1'b0;
        PE_reset = '0;
        PE_finish = '0;
        wr_en_next = 1'b0;
        @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_out", out_BRAM_CONV, 0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // rows 0..2 of the IFM cover pixels (0,0) and (0,1); weights share the first 72 cycles
    task automatic load(input vec_t v);
        wr_rd_en_IFM = 1'b1;
        for (int a = 0; a < 696; a++) begin
            addr = a;
            data_in_IFM = (v.one_hot && a == 0) ? 32'h01000000 : {4{v.ifm_b}};
            wr_rd_en_Weight = (a < 72);
            for (int k = 0; k < 16; k++)
                w_in[k] = v.w_idx ? {4{8'(k)}} : {4{v.w_b}};
            @(negedge clk);
        end
        wr_rd_en_IFM = 1'b0;
        wr_rd_en_Weight = 1'b0;
    endtask

    task automatic run(input int npix);
        fork
            begin : drv
                cal_start = 1'b1;
                for (int t = 0; t < 36 * npix + 3; t++) begin
                    PE_reset  = (t >= 3 && (t - 3) % 36 == 0) ? 16'hFFFF : 16'h0000;
                    PE_finish = (t >= 38 && (t - 38) % 36 == 0) ? 16'hFFFF : 16'h0000;
                    if (PE_finish[0])
                        q.push_back(exp_pix[(t - 38) / 36]);
                    if (t == 37) check("ifm_addr_p1_s0", dut.r_ifm_addr, 4);
                    if (t == 49) check("ifm_addr_p1_s12", dut.r_ifm_addr, 236);
                    if (t == 72) check("ifm_addr_p1_s35", dut.r_ifm_addr, 479);
                    @(negedge clk);
                end
                cal_start = 1'b0;
                PE_reset  = '0;
                PE_finish = '0;
            end
            begin : mon
                logic [127:0] e;
                int n;
                for (int p = 0; p < npix; p++) begin
                    n = 0;
                    while (valid == 16'h0000 && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n == 200) begin
                        checks++;
                        errors++;
                        $display("FAIL valid_timeout: no valid pulse for pixel %0d", p);
                        break;
                    end
                    check("valid_all", valid, 16'hFFFF);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: valid for pixel %0d with no expected entry", p);
                        e = '0;
                    end else
                        e = q.pop_front();
                    @(negedge clk);
                    check("valid_pulse", valid, 0);
                    wr_en_next = 1'b1;
                    for (int m = 0; m < 4; m++) begin
                        addr_ram_next_wr = p * 4 + m;
                        control_mux = 2'(m);
                        @(negedge clk);
                    end
                    wr_en_next = 1'b0;
                    for (int m = 0; m < 4; m++) begin
                        addr_ram_next_rd = p * 4 + m;
                        @(negedge clk);
                        check("packed_word", out_BRAM_CONV, pack(e, m));
                    end
                end
            end
        join
    endtask

    initial begin
        reset = 1'b0;
        wr_rd_en_IFM = 1'b0;
        wr_rd_en_Weight = 1'b0;
        addr = '0;
        data_in_IFM = '0;
        for (int k = 0; k < 16; k++) w_in[k] = '0;
        cal_start = 1'b0;
        PE_reset = '0;
        PE_finish = '0;
        wr_en_next = 1'b0;
        addr_ram_next_wr = '0;
        addr_ram_next_rd = '0;
        control_mux = '0;

        tbl[0] = '{8'h01, 8'h01, 1'b0, 1'b0, {16{8'h90}}, {16{8'h90}}};
        tbl[1] = '{8'h01, 8'hFF, 1'b0, 1'b0, {16{8'h00}}, {16{8'h00}}};
        tbl[2] = '{8'h02, 8'h7F, 1'b0, 1'b0, {16{8'hFF}}, {16{8'hFF}}};
        tbl[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, {16{8'hFF}}, {16{8'hFF}}};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 128'h0};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            load(tbl[i]);
            do_reset();
            exp_pix[0] = tbl[i].exp0;
            exp_pix[1] = tbl[i].exp1;
            run(2);
        end

        // packed word is now all zero; address 0 still holds 0x00010203
        addr_ram_next_rd = 0;
        addr_ram_next_wr = 0;
        control_mux = 2'd0;
        wr_en_next = 1'b1;
        @(negedge clk);
        wr_en_next = 1'b0;
        check("rdw_old_data", out_BRAM_CONV, 32'h00010203);
        @(negedge clk);
        check("rdw_new_data", out_BRAM_CONV, 32'h00000000);

        do_reset();
        cal_start = 1'b1;
        repeat (5) @(negedge clk);
        cal_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pause_hold", dut.r_ifm_addr, 4);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        check("pause_resume", dut.r_ifm_addr, 5);

        load(tbl[0]);
        do_reset();
        addr_ram_next_rd = 1;
        cal_start = 1'b1;
        for (int t = 0; t < 39; t++) begin
            PE_reset  = (t == 3) ? 16'hFFFF : 16'h0000;
            PE_finish = (t == 38) ? 16'hFFFF : 16'h0000;
            @(negedge clk);
        end
        PE_finish = '0;
        check("pre_reset_valid", valid, 16'hFFFF);
        check("pre_reset_out", out_BRAM_CONV, 32'h04050607);
        #2 reset = 1'b0;
        #1;
        check("async_reset_valid", valid, 0);
        check("async_reset_out", out_BRAM_CONV, 0);
        @(negedge clk);
        reset = 1'b1;
        cal_start = 1'b0;
        @(negedge clk);
        exp_pix[0] = {16{8'h90}};
        exp_pix[1] = {16{8'h90}};
        run(2);

        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sub_top_2_conv.md
Name: sub_top_2_conv

Overview:
- 3x3 convolution tile engine: IFM 58x58x16 (int8, HWC) with 3x3x16 kernels gives a 56x56 OFM, 16 output channels per pass, 2 passes (32 channels).
- Contains the IFM BRAM, 16 weight BRAMs and an IFM/weight address generator.
- Contains 16 MAC PEs, a 4:1 byte packer and an output BRAM that feeds the next layer.

Parameters:
- IFM_W, 58, padded IFM width/height.
- OFM_W, 56, OFM width/height.
- IFM_DEPTH, 13456, IFM words (58*58*16/4).
- W_DEPTH, 72, weight words per PE (2 passes x 36).
- OUT_DEPTH, 32768, output BRAM words.
- NUM_PE, 16, PEs/filters per pass.
- NUM_PASS, 2, filter groups.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- wr_rd_en_IFM  in  1  1 = write data_in_IFM to IFM[addr].
- wr_rd_en_Weight  in  1  1 = write each data_in_Weight_k to weight BRAM k at [addr].
- addr  in  32  load word address; low bits used.
- data_in_IFM  in  32  4 IFM bytes, lowest byte index in [31:24].
- data_in_Weight_0..15  in  32 each  4 weight bytes for PE k, same packing.
- cal_start  in  1  level; 1 = run the address generator.
- PE_reset  in  16  per PE, first-MAC strobe.
- PE_finish  in  16  per PE, last-MAC strobe.
- valid  out  16  per PE, 1-cycle pulse when a result is ready.
- wr_en_next  in  1  output BRAM write enable.
- addr_ram_next_wr  in  32  output BRAM write word address.
- addr_ram_next_rd  in  32  output BRAM read word address.
- control_mux  in  2  selects the PE group packed into the write word.
- out_BRAM_CONV  out  32  registered output BRAM read data.

Behaviour:
- Reset (reset=0, asynchronous): valid=0, out_BRAM_CONV=0, PE accumulators and result registers 0, generator idle with counters 0. Memory contents are not reset.
- Load phase (cal_start=0):
  - IFM and weight writes are synchronous, on addr[13:0] and addr[6:0] respectively.
  - Both enables high at once writes both memories.
- Address generator:
  - Counts while cal_start=1, starting on the first rising edge with cal_start=1.
  - Step s = 0..35 within an output pixel: kr = s/12, kc = (s%12)/4, cw = s%4.
  - IFM word address = ((r+kr)*58 + (c+kc))*4 + cw.
  - Weight word address = pass*36 + s, identical for all 16 PEs.
  - After s=35, c increments; then r; then pass.
  - After pass 1, r 55, c 55, s 35, the generator stops and holds.
  - Dropping cal_start pauses counting. Counters clear only on reset.
- BRAM reads: 1-cycle latency plus one pipeline register. The word addressed at generator edge n reaches the PEs on edge n+2. Step 0 of pixel 0 therefore arrives on the edge 3 cycles after cal_start is sampled; the controller asserts PE_reset on that edge.
- PE k, each edge:
  - prod = sum over j=0..3 of ifm_byte_j (unsigned) x w_byte_j (signed); acc is 32-bit signed.
  - PE_reset[k]=1: acc <= prod. Otherwise acc <= acc + prod.
  - PE_finish[k]=1: result_k <= clamp(acc+prod, 0, 255) (ReLU + saturate) and valid[k] <= 1 next cycle only.
  - result_k holds until the next finish.
  - PE_reset and PE_finish together: result = clamp(prod).
- Packing: write word = {result[4m], result[4m+1], result[4m+2], result[4m+3]} with m = control_mux; result[4m] goes to [31:24].
- Output BRAM:
  - wr_en_next=1 writes the packed word to [addr_ram_next_wr[14:0]].
  - Every edge, out_BRAM_CONV <= mem[addr_ram_next_rd[14:0]] (1-cycle latency).
  - Same-address read and write returns the old data.
- Address bits above the used width are ignored; there is no range check.

Decomposition:
- Package conv_pkg: IFM_W, OFM_W, depths, NUM_PE, NUM_PASS, and STEPS_PER_PIX=36.
- One sub-module, conv_pe: 4-lane MAC, accumulator, clamp, valid.
- BRAMs are inferred inline.

Test Plan:
- Load IFM all 0x01, weights all 0x01; cal_start, then PE_reset/PE_finish every 36 cycles -> each valid pulse has result=144 clamped to 0x90; packed word 0x90909090.
- Weights 0xFF (-1) -> acc=-144 -> result 0x00 (ReLU).
- IFM 0x02, weights 0x7F -> acc 36576 -> result saturates to 0xFF.
- Weight for PE k = k (all bytes), IFM 0 except one 1 at word 0 byte 0 -> pixel (0,0) result_k=k; control_mux 0..3 writes at addr 0..3 read back 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F.
- Check the IFM address sequence: pixel (0,1) step 0 = 4, step 12 = 236 (row 1), last step 35 = 479.
- Assert reset mid-computation -> valid=0 and out_BRAM_CONV=0 immediately; restart from pixel (0,0) pass 0.
